// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers used by the arbiter and its requester-side mux.
package arb_pkg;

  localparam int N_DEF  = 8;
  localparam int DW_DEF = 32;
  // Widest request vector the helpers below can handle.
  localparam int MAX_N  = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) cnt += 32'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/arb_grant_mux_if.sv
// Client, arbiter and downstream signals of arb_grant_mux.
// The slave modport is the mux itself; master is the surrounding environment.
interface arb_grant_mux_if #(
  parameter int N  = 8,
  parameter int DW = 32
);
  localparam int CW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ch;
  logic            out_last;
  logic            out_ready;
  logic            err_grant;
  logic            err_timeout;

  modport master (
    output in_valid, in_data, in_last, grant, out_ready,
    input  in_ready, req, out_valid, out_data, out_ch, out_last, err_grant, err_timeout
  );

  modport slave (
    input  in_valid, in_data, in_last, grant, out_ready,
    output in_ready, req, out_valid, out_data, out_ch, out_last, err_grant, err_timeout
  );

endinterface

// File: rtl/arb_onehot2bin.sv
// One-hot to binary encoder; gok flags a vector with exactly one bit set.
module arb_onehot2bin
  import arb_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  onehot_in,
  output logic [CW-1:0] bin,
  output logic          gok
);

  // OR of indices is only meaningful when gok is set; callers ignore bin otherwise.
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_in[i]) bin = bin | CW'(i);
    end
  end

  assign gok = (popcount(MAX_N'(onehot_in)) == 1);

endmodule

// File: rtl/arb_grant_mux.sv
// Requester side of the round-robin arbiter: drives req, follows grant, locks to a
// channel for a whole packet and muxes its beats into one registered output stream.
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_grant_mux_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [0:0]    ST_IDLE = IDLE;
  localparam logic [0:0]    ST_LOCK = LOCK;

  logic [0:0]    state;
  logic [CW-1:0] lock_ch;
  logic [TW-1:0] timer;
  logic [CW-1:0] gidx;
  logic          gok;
  logic [N-1:0]  lock_oh;
  logic          free;
  logic          acc;
  logic [CW-1:0] acc_ch;
  logic [DW-1:0] acc_data;
  logic          acc_last;
  logic          multi_grant;

  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] out_ch_q;
  logic          out_last_q;
  logic          err_grant_q;
  logic          err_timeout_q;

  arb_onehot2bin #(.N(N)) u_grant_enc (
    .onehot_in (bus.grant),
    .bin       (gidx),
    .gok       (gok)
  );

  assign lock_oh     = N'(onehot(32'(lock_ch)));
  assign free        = !out_valid_q || bus.out_ready;
  assign multi_grant = (popcount(MAX_N'(bus.grant)) >= 2);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    bus.req = '0;
    acc     = 1'b0;
    acc_ch  = gidx;
    if (state == ST_IDLE) begin
      bus.req = bus.in_valid;
      acc     = gok && bus.in_valid[gidx] && free;
    end else begin
      // The lock holds even while the owner has nothing to send.
      acc_ch  = lock_ch;
      bus.req = lock_oh & {N{bus.in_valid[lock_ch]}};
      acc     = (bus.grant == lock_oh) && bus.in_valid[lock_ch] && free;
    end
  end

  assign bus.in_ready = acc ? N'(onehot(32'(acc_ch))) : '0;
  assign acc_data     = bus.in_data[int'(acc_ch)*DW +: DW];
  assign acc_last     = bus.in_last[acc_ch];

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      lock_ch       <= '0;
      timer         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ch_q      <= '0;
      out_last_q    <= 1'b0;
      err_grant_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_grant_q   <= multi_grant;
      err_timeout_q <= 1'b0;

      if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_data;
        out_ch_q    <= acc_ch;
        out_last_q  <= acc_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (acc && !acc_last) begin
            state   <= ST_LOCK;
            lock_ch <= acc_ch;
            timer   <= '0;
          end
        end
        ST_LOCK: begin
          if (acc) begin
            timer <= '0;
            if (acc_last) state <= ST_IDLE;
          end else if (timer == T_LAST) begin
            // Stalled owner: drop the lock; the partial packet is left unterminated.
            err_timeout_q <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_last    = out_last_q;
  assign bus.err_grant   = err_grant_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Bench for arb_grant_mux: directed scenarios plus randomized traffic against a
// packet-level reference model.
module tb_arb_grant_mux;

  localparam int N       = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
  localparam int CW      = $clog2(N);
  localparam int RW      = 4 + CW + DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_grant_mux_if #(.N(N), .DW(DW)) bus ();

  arb_grant_mux #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: is a packet open, on which channel, how many cycles without progress.
  bit            m_locked;
  int            m_ch;
  int            m_idle;
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_oc;
  bit            m_ol;
  bit            m_eg;
  bit            m_et;
  logic [N-1:0]  exp_req;
  logic [N-1:0]  exp_ready;
  int            acc;

  task automatic model_reset();
    m_locked = 0; m_ch = 0; m_idle = 0;
    m_ov = 0; m_od = '0; m_oc = 0; m_ol = 0; m_eg = 0; m_et = 0;
  endtask

  task automatic model_comb();
    int g;
    bit room;
    g    = -1;
    room = !m_ov || bus.out_ready;
    if ($countones(bus.grant) == 1)
      for (int i = 0; i < N; i++) if (bus.grant[i]) g = i;
    acc = -1;
    if (!m_locked) begin
      exp_req = bus.in_valid;
      if (g >= 0 && bus.in_valid[g] && room) acc = g;
    end else begin
      exp_req = bus.in_valid[m_ch] ? (N'(1) << m_ch) : '0;
      if (g == m_ch && bus.in_valid[m_ch] && room) acc = m_ch;
    end
    exp_ready = (acc >= 0) ? (N'(1) << acc) : '0;
  endtask

  task automatic model_seq();
    m_eg = ($countones(bus.grant) >= 2);
    m_et = 0;
    if (acc >= 0) begin
      m_ov = 1; m_od = bus.in_data[acc*DW +: DW]; m_oc = acc; m_ol = bus.in_last[acc];
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    if (!m_locked) begin
      if (acc >= 0 && !bus.in_last[acc]) begin m_locked = 1; m_ch = acc; m_idle = 0; end
    end else if (acc >= 0) begin
      m_idle = 0;
      if (bus.in_last[acc]) m_locked = 0;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_et = 1; m_locked = 0; end
    end
  endtask

  function automatic logic [RW-1:0] exp_regs();
    return {m_ov, CW'(m_oc), m_ol, m_eg, m_et, m_od};
  endfunction

  function automatic logic [RW-1:0] dut_regs();
    return {bus.out_valid, bus.out_ch, bus.out_last, bus.err_grant, bus.err_timeout, bus.out_data};
  endfunction

  // Inputs change at the falling edge; combinational outputs are sampled 1 ns later.
  task automatic eval();
    #1;
    model_comb();
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    bus.in_data[ch*DW +: DW] = v;
  endtask

  task automatic drain();
    bus.in_valid = '0; bus.in_last = '0; bus.grant = '0; bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 8'hA5; bus.in_last = '0; bus.in_data = '0; bus.grant = '0; bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (dut_regs() !== '0) $display("FAIL reset_regs got=%h exp=0", dut_regs()); else n_pass++;
    n_checks++; if (bus.req !== 8'hA5) $display("FAIL reset_req got=%h exp=a5", bus.req); else n_pass++;
    n_checks++; if (bus.in_ready !== 8'h00) $display("FAIL reset_ready got=%h exp=00", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] d;
    drain();
    d = $urandom;
    bus.in_valid = 8'h01; bus.in_last = 8'h01; bus.grant = 8'h01; bus.out_ready = 1'b1;
    set_data(0, d);
    eval();
    n_checks++; if (bus.in_ready !== 8'h01) $display("FAIL single_ready got=%h exp=01", bus.in_ready); else n_pass++;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_ch, bus.out_last, bus.out_data} !== {1'b1, 3'd0, 1'b1, d})
      $display("FAIL single_out got=%b/%0d/%b/%h exp=1/0/1/%h", bus.out_valid, bus.out_ch, bus.out_last, bus.out_data, d);
    else n_pass++;
    bus.in_valid = 8'h06; bus.in_last = '0; bus.grant = '0;
    eval();
    n_checks++; if (bus.req !== 8'h06) $display("FAIL single_idle_req got=%h exp=06", bus.req); else n_pass++;
    tick();
  endtask

  task automatic test_locked_packet();
    logic [7:0]    gseq [4] = '{8'h04, 8'h20, 8'h04, 8'h04};
    logic [DW-1:0] beats[3];
    logic [7:0]    rq;
    int k;
    drain();
    for (int i = 0; i < 3; i++) beats[i] = $urandom;
    bus.in_valid = 8'h24; bus.in_last = '0; bus.out_ready = 1'b1;
    set_data(5, $urandom);
    k = 0;
    for (int s = 0; s < 4; s++) begin
      bus.grant = gseq[s];
      set_data(2, beats[k]);
      bus.in_last[2] = (k == 2);
      eval();
      rq = (s == 0) ? 8'h24 : 8'h04;
      n_checks++; if (bus.req !== rq) $display("FAIL lock_req s=%0d got=%h exp=%h", s, bus.req, rq); else n_pass++;
      rq = (s == 1) ? 8'h00 : 8'h04;
      n_checks++; if (bus.in_ready !== rq) $display("FAIL lock_ready s=%0d got=%h exp=%h", s, bus.in_ready, rq); else n_pass++;
      tick();
      if (s != 1) begin
        n_checks++;
        if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 3'd2, beats[k]})
          $display("FAIL lock_beat k=%0d got=%b/%0d/%h exp=1/2/%h", k, bus.out_valid, bus.out_ch, bus.out_data, beats[k]);
        else n_pass++;
        k++;
      end
    end
    bus.grant = '0;
    eval();
    n_checks++; if (bus.req !== 8'h24) $display("FAIL lock_release_req got=%h exp=24", bus.req); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[4];
    drain();
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    bus.in_valid = 8'h08; bus.in_last = '0; bus.grant = 8'h08; bus.out_ready = 1'b0;
    set_data(3, d[0]);
    tick();
    set_data(3, d[1]);
    repeat (2) begin
      eval();
      n_checks++; if (bus.in_ready !== 8'h00) $display("FAIL bp_stall_ready got=%h exp=00", bus.in_ready); else n_pass++;
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, d[0]})
        $display("FAIL bp_hold got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, d[0]);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      set_data(3, d[i]);
      bus.in_last[3] = (i == 3);
      eval();
      n_checks++; if (bus.in_ready !== 8'h08) $display("FAIL bp_stream_ready i=%0d got=%h exp=08", i, bus.in_ready); else n_pass++;
      tick();
      n_checks++; if (dut_regs() !== exp_regs()) $display("FAIL bp_stream i=%0d got=%h exp=%h", i, dut_regs(), exp_regs()); else n_pass++;
    end
  endtask

  task automatic test_illegal_grant();
    logic [DW-1:0] d;
    drain();
    d = $urandom;
    bus.in_valid = 8'h40; bus.in_last = 8'h40; bus.grant = 8'h40; bus.out_ready = 1'b0;
    set_data(6, d);
    tick();
    bus.in_valid = 8'h03; bus.in_last = '0; bus.grant = 8'h03;
    eval();
    n_checks++; if (bus.in_ready !== 8'h00) $display("FAIL illegal_ready got=%h exp=00", bus.in_ready); else n_pass++;
    tick();
    n_checks++;
    if ({bus.err_grant, bus.out_valid, bus.out_ch, bus.out_last, bus.out_data} !== {1'b1, 1'b1, 3'd6, 1'b1, d})
      $display("FAIL illegal_pulse got=%b/%b/%0d/%b/%h exp=1/1/6/1/%h",
               bus.err_grant, bus.out_valid, bus.out_ch, bus.out_last, bus.out_data, d);
    else n_pass++;
    bus.grant = '0;
    tick();
    n_checks++; if (bus.err_grant !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", bus.err_grant); else n_pass++;
  endtask

  task automatic test_timeout();
    drain();
    bus.in_valid = 8'h02; bus.in_last = '0; bus.grant = 8'h02; bus.out_ready = 1'b1;
    set_data(1, $urandom);
    tick();
    bus.in_valid = 8'h90; bus.grant = 8'h10;
    for (int k = 1; k <= TIMEOUT; k++) begin
      eval();
      n_checks++; if (bus.req !== 8'h00) $display("FAIL to_lock_req k=%0d got=%h exp=00", k, bus.req); else n_pass++;
      tick();
      n_checks++;
      if (bus.err_timeout !== (k == TIMEOUT)) $display("FAIL to_pulse k=%0d got=%b exp=%b", k, bus.err_timeout, k == TIMEOUT);
      else n_pass++;
    end
    bus.grant = '0;
    eval();
    n_checks++; if (bus.req !== 8'h90) $display("FAIL to_idle_req got=%h exp=90", bus.req); else n_pass++;
    tick();
    n_checks++; if (bus.err_timeout !== 1'b0) $display("FAIL to_clear got=%b exp=0", bus.err_timeout); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    logic [DW-1:0] d[2];
    drain();
    bus.in_valid = 8'h10; bus.in_last = '0; bus.grant = 8'h10; bus.out_ready = 1'b0;
    set_data(4, $urandom);
    tick();
    bus.in_valid = 8'h30; bus.grant = '0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.req !== 8'h30) $display("FAIL rstmid_req got=%h exp=30", bus.req); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    d[0] = $urandom; d[1] = $urandom;
    bus.in_valid = 8'h80; bus.grant = 8'h80; bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_data(7, d[i]);
      bus.in_last[7] = (i == 1);
      eval();
      n_checks++; if (bus.in_ready !== 8'h80) $display("FAIL rstmid_ready i=%0d got=%h exp=80", i, bus.in_ready); else n_pass++;
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_ch, bus.out_last, bus.out_data} !== {1'b1, 3'd7, i == 1, d[i]})
        $display("FAIL rstmid_beat i=%0d got=%b/%0d/%b/%h exp=1/7/%0d/%h",
                 i, bus.out_valid, bus.out_ch, bus.out_last, bus.out_data, i == 1, d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev_req;
    int cand[$];
    int r, a, b;
    drain();
    prev_req = '0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = N'($urandom);
      bus.in_last   = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        bus.grant = (N'(1) << a) | (N'(1) << b);
      end else if (r < 3) begin
        bus.grant = '0;
      end else begin
        cand.delete();
        for (int i = 0; i < N; i++) if (prev_req[i]) cand.push_back(i);
        a = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : $urandom_range(0, N - 1);
        bus.grant = N'(1) << a;
      end
      eval();
      n_checks++; if (bus.req !== exp_req) $display("FAIL rnd_req c=%0d got=%h exp=%h", c, bus.req, exp_req); else n_pass++;
      n_checks++; if (bus.in_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got=%h exp=%h", c, bus.in_ready, exp_ready); else n_pass++;
      prev_req = exp_req;
      tick();
      n_checks++; if (dut_regs() !== exp_regs()) $display("FAIL rnd_regs c=%0d got=%h exp=%h", c, dut_regs(), exp_regs()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_locked_packet();
    test_backpressure();
    test_illegal_grant();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
